// File: rtl/frame_fifo_mii_tx.sv
// Drains length-prefixed frames from the egress byte FIFO and sends them on MII TX
// with preamble/SFD, inter-frame gap, underrun abort and oversize-length drop.
module frame_fifo_mii_tx #(
    parameter int MAX_LEN     = 1518,
    parameter int IFG_NIBBLES = 24
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_empty,
    output logic       fifo_ren,
    output logic [3:0] txd,
    output logic       tx_en,
    output logic       tx_er,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun_err,
    output logic       len_err
);

    localparam logic [15:0] MAX_L    = 16'(MAX_LEN);
    localparam logic [15:0] IFG_LAST = 16'(IFG_NIBBLES - 1);

    typedef enum logic [2:0] {
        IDLE, HDR_H, HDR_L, PREAMBLE, DATA, ABORT, DRAIN, IFG
    } state_t;

    state_t      state, state_nxt;
    logic        rvalid;
    logic [7:0]  len_hi;
    logic [7:0]  byte_reg;
    logic [15:0] rem;
    logic [15:0] left;
    logic [15:0] cnt;
    logic        phase;
    logic        err_cyc;

    logic [15:0] len_full;
    logic        need_fetch;
    logic        underrun;
    logic        data_rd;
    logic        ren_c;
    logic [3:0]  txd_d;
    logic        tx_en_d;
    logic        tx_er_d;
    logic        done_d;
    logic        uerr_d;
    logic        lerr_d;

    assign len_full = {len_hi, fifo_dout};

    // A prefetch is due at preamble nibble 14 and at every low-nibble cycle while
    // bytes remain; an empty FIFO at that moment is an underrun.
    assign need_fetch = !err_cyc &&
                        ((state == PREAMBLE && cnt == 16'd14) ||
                         (state == DATA && !phase && rem != 16'd0));
    assign underrun   = need_fetch && fifo_empty;

    assign fifo_ren = ren_c && !rst;
    assign busy     = (state != IDLE);
    assign data_rd  = fifo_ren && (state == PREAMBLE || state == DATA || state == DRAIN);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (!fifo_empty) state_nxt = HDR_H;
            HDR_H:    if (!fifo_empty) state_nxt = HDR_L;
            HDR_L: begin
                if (rvalid) begin
                    if (len_full == 16'd0)  state_nxt = IFG;
                    else if (len_full > MAX_L) state_nxt = DRAIN;
                    else                    state_nxt = PREAMBLE;
                end
            end
            PREAMBLE: begin
                if (err_cyc)                state_nxt = ABORT;
                else if (cnt == 16'd15)     state_nxt = DATA;
            end
            DATA: begin
                if (err_cyc)                          state_nxt = ABORT;
                else if (phase && left == 16'd1)      state_nxt = IFG;
            end
            ABORT:    state_nxt = DRAIN;
            DRAIN:    if (rem == 16'd0) state_nxt = IFG;
            IFG:      if (cnt == IFG_LAST) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // The *_d values are what the MII pins show next cycle, so each state
    // prepares the nibble belonging to the following cycle.
    always_comb begin
        ren_c   = 1'b0;
        txd_d   = 4'h0;
        tx_en_d = 1'b0;
        tx_er_d = 1'b0;
        done_d  = 1'b0;
        uerr_d  = 1'b0;
        lerr_d  = 1'b0;
        case (state)
            IDLE:  ren_c = !fifo_empty;
            HDR_H: ren_c = !fifo_empty;
            HDR_L: begin
                if (rvalid) begin
                    if (len_full == 16'd0 || len_full > MAX_L) begin
                        lerr_d = 1'b1;
                    end else begin
                        tx_en_d = 1'b1;
                        txd_d   = 4'h5;
                    end
                end
            end
            PREAMBLE: begin
                if (err_cyc) begin
                    uerr_d = 1'b1;
                end else if (underrun) begin
                    tx_en_d = 1'b1;
                    tx_er_d = 1'b1;
                end else begin
                    ren_c   = need_fetch;
                    tx_en_d = 1'b1;
                    if (cnt == 16'd15)      txd_d = fifo_dout[3:0];
                    else if (cnt == 16'd14) txd_d = 4'hD;
                    else                    txd_d = 4'h5;
                end
            end
            DATA: begin
                if (err_cyc) begin
                    uerr_d = 1'b1;
                end else if (underrun) begin
                    tx_en_d = 1'b1;
                    tx_er_d = 1'b1;
                end else begin
                    ren_c = need_fetch;
                    if (!phase) begin
                        tx_en_d = 1'b1;
                        txd_d   = byte_reg[7:4];
                    end else if (left == 16'd1) begin
                        done_d = 1'b1;
                    end else begin
                        tx_en_d = 1'b1;
                        txd_d   = fifo_dout[3:0];
                    end
                end
            end
            DRAIN:   ren_c = !fifo_empty && rem != 16'd0;
            default: ren_c = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rvalid       <= 1'b0;
            len_hi       <= 8'h00;
            byte_reg     <= 8'h00;
            rem          <= 16'd0;
            left         <= 16'd0;
            cnt          <= 16'd0;
            phase        <= 1'b0;
            err_cyc      <= 1'b0;
            txd          <= 4'h0;
            tx_en        <= 1'b0;
            tx_er        <= 1'b0;
            frame_done   <= 1'b0;
            underrun_err <= 1'b0;
            len_err      <= 1'b0;
        end else begin
            rvalid <= fifo_ren && !fifo_empty;
            if (state == HDR_H && rvalid) len_hi <= fifo_dout;
            if (rvalid && (state == PREAMBLE || state == DATA)) byte_reg <= fifo_dout;

            // rem counts bytes not yet read; it saturates at zero.
            if (state == HDR_L && rvalid)        rem <= len_full;
            else if (data_rd && rem != 16'd0)    rem <= rem - 16'd1;

            if (state == HDR_L && rvalid)
                left <= len_full;
            else if (state == DATA && phase && !err_cyc && left != 16'd0)
                left <= left - 16'd1;

            cnt     <= (state_nxt == state && (state == PREAMBLE || state == IFG))
                       ? cnt + 16'd1 : 16'd0;
            phase   <= (state == DATA && !err_cyc) ? ~phase : 1'b0;
            err_cyc <= underrun;

            txd          <= txd_d;
            tx_en        <= tx_en_d;
            tx_er        <= tx_er_d;
            frame_done   <= done_d;
            underrun_err <= uerr_d;
            len_err      <= lerr_d;
        end
    end

endmodule
